// File: rtl/daqpkt_pkg.sv
// +--------------------------------------------------------------------------+
// | daqpkt_pkg: shared types and helpers for daq_frame_packer.                |
// | Rev 1.0 - initial release (checksum option: DAQPKT_CHKSUM_EN)             |
// +--------------------------------------------------------------------------+
`default_nettype none

package daqpkt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR0  = 3'd1,
    ST_HDR1  = 3'd2,
    ST_SEQ   = 3'd3,
    ST_NCH   = 3'd4,
    ST_LOAD  = 3'd5,
    ST_SHIFT = 3'd6,
    ST_CSUM  = 3'd7
  } state_e;

  localparam logic [7:0] DEF_SYNC0 = 8'hA5;
  localparam logic [7:0] DEF_SYNC1 = 8'h5A;

  function automatic int daqpkt_bps(input int sample_w);
    return sample_w / 8;
  endfunction

  // Header (4 bytes) + payload + optional trailing checksum byte.
  function automatic int daqpkt_frame_len(input int num_ch, input int sample_w, input bit chksum);
    return 4 + num_ch * daqpkt_bps(sample_w) + (chksum ? 1 : 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/daqpkt_serializer.sv
// +--------------------------------------------------------------------------+
// | daqpkt_serializer: loads one sample, shifts bytes out MSB-first.          |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

module daqpkt_serializer
  import daqpkt_pkg::*;
#(
  parameter int SAMPLE_W = 16
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                load_i,
  input  logic [SAMPLE_W-1:0] data_i,
  input  logic                adv_i,
  output logic [7:0]          byte_o,
  output logic                last_o
);

  localparam int BPS   = daqpkt_bps(SAMPLE_W);
  localparam int IDX_W = (BPS > 1) ? $clog2(BPS) : 1;

  logic [SAMPLE_W-1:0] sr_q, sr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  always_comb begin
    sr_d  = sr_q;
    idx_d = idx_q;
    if (load_i) begin
      sr_d  = data_i;
      idx_d = '0;
    end else if (adv_i) begin
      sr_d  = sr_q << 8;
      idx_d = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      sr_q  <= '0;
      idx_q <= '0;
    end else begin
      sr_q  <= sr_d;
      idx_q <= idx_d;
    end
  end

  assign byte_o = sr_q[SAMPLE_W-1 -: 8];
  assign last_o = (idx_q == IDX_W'(BPS - 1));

endmodule

`default_nettype wire

// File: rtl/daq_frame_packer.sv
// +--------------------------------------------------------------------------+
// | daq_frame_packer: frames NUM_CH ADC samples into a byte packet for FIFO.  |
// | Rev 1.0 - initial release (checksum option: DAQPKT_CHKSUM_EN)             |
// +--------------------------------------------------------------------------+
`default_nettype none

module daq_frame_packer
  import daqpkt_pkg::*;
#(
  parameter int         NUM_CH   = 8,
  parameter int         SAMPLE_W = 16,
  parameter logic [7:0] SYNC0    = DEF_SYNC0,
  parameter logic [7:0] SYNC1    = DEF_SYNC1
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                en_i,
  input  logic                sample_valid_i,
  input  logic [SAMPLE_W-1:0] sample_data_i,
  output logic                sample_ready_o,
  input  logic                fifo_full_i,
  output logic                fifo_wr_o,
  output logic [7:0]          fifo_data_o,
  output logic                busy_o,
  output logic [7:0]          seq_o
);

  localparam logic [7:0] NCH_BYTE = 8'(NUM_CH);
  localparam logic [7:0] LAST_CH  = 8'(NUM_CH - 1);

  state_e     state_q, state_d;
  logic [7:0] seq_q, seq_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ser_load, ser_adv, ser_last;
  logic [7:0] ser_byte;
`ifdef DAQPKT_CHKSUM_EN
  logic [7:0] csum_q, csum_d;
`endif

  daqpkt_serializer #(
    .SAMPLE_W (SAMPLE_W)
  ) u_ser (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .load_i   (ser_load),
    .data_i   (sample_data_i),
    .adv_i    (ser_adv),
    .byte_o   (ser_byte),
    .last_o   (ser_last)
  );

  always_comb begin
    state_d        = state_q;
    seq_d          = seq_q;
    cnt_d          = cnt_q;
    fifo_wr_o      = 1'b0;
    fifo_data_o    = 8'h00;
    sample_ready_o = 1'b0;
    ser_load       = 1'b0;
    ser_adv        = 1'b0;
`ifdef DAQPKT_CHKSUM_EN
    csum_d         = csum_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (en_i) begin
          state_d = ST_HDR0;
`ifdef DAQPKT_CHKSUM_EN
          csum_d  = 8'h00;
`endif
        end
      end
      ST_HDR0: begin
        fifo_data_o = SYNC0;
        if (!fifo_full_i) state_d = ST_HDR1;
      end
      ST_HDR1: begin
        fifo_data_o = SYNC1;
        if (!fifo_full_i) state_d = ST_SEQ;
      end
      ST_SEQ: begin
        fifo_data_o = seq_q;
        if (!fifo_full_i) state_d = ST_NCH;
      end
      ST_NCH: begin
        fifo_data_o = NCH_BYTE;
        if (!fifo_full_i) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        sample_ready_o = 1'b1;
        if (sample_valid_i) begin
          ser_load = 1'b1;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        fifo_data_o = ser_byte;
        if (!fifo_full_i) begin
          ser_adv = 1'b1;
          if (ser_last) begin
            if (cnt_q == LAST_CH) begin
`ifdef DAQPKT_CHKSUM_EN
              state_d = ST_CSUM;
`else
              state_d = ST_IDLE;
              seq_d   = seq_q + 8'd1;
              cnt_d   = 8'd0;
`endif
            end else begin
              cnt_d   = cnt_q + 8'd1;
              state_d = ST_LOAD;
            end
          end
        end
      end
`ifdef DAQPKT_CHKSUM_EN
      ST_CSUM: begin
        fifo_data_o = csum_q;
        if (!fifo_full_i) begin
          state_d = ST_IDLE;
          seq_d   = seq_q + 8'd1;
          cnt_d   = 8'd0;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    fifo_wr_o = !fifo_full_i &&
                (state_q inside {ST_HDR0, ST_HDR1, ST_SEQ, ST_NCH, ST_SHIFT, ST_CSUM});
`ifdef DAQPKT_CHKSUM_EN
    // Checksum covers SEQ, NCH and payload, not the sync bytes.
    if (fifo_wr_o && (state_q inside {ST_SEQ, ST_NCH, ST_SHIFT}))
      csum_d = csum_q ^ fifo_data_o;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
      seq_q   <= 8'd0;
      cnt_q   <= 8'd0;
`ifdef DAQPKT_CHKSUM_EN
      csum_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      cnt_q   <= cnt_d;
`ifdef DAQPKT_CHKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign busy_o = (state_q != ST_IDLE);
  assign seq_o  = seq_q;

endmodule

`default_nettype wire

// File: tb/tb_daq_frame_packer.sv
// +--------------------------------------------------------------------------+
// | tb_daq_frame_packer: directed bench for daq_frame_packer (2 ch, 16 bit).  |
// | Rev 1.0 - initial release (checksum option: DAQPKT_CHKSUM_EN)             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_daq_frame_packer;
  import daqpkt_pkg::*;

`ifdef DAQPKT_CHKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int FLEN = daqpkt_frame_len(2, 16, CHK);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        valid = 1'b0;
  logic [15:0] sdata = 16'h0;
  logic        ready;
  logic        full = 1'b0;
  logic        wr;
  logic [7:0]  wdata;
  logic        busy;
  logic [7:0]  seq;

  int total = 0;
  int bad = 0;
  logic [7:0] q[$];

  daq_frame_packer #(
    .NUM_CH   (2),
    .SAMPLE_W (16)
  ) dut (
    .clk_i          (clk),
    .reset_ni       (rst_n),
    .en_i           (en),
    .sample_valid_i (valid),
    .sample_data_i  (sdata),
    .sample_ready_o (ready),
    .fifo_full_i    (full),
    .fifo_wr_o      (wr),
    .fifo_data_o    (wdata),
    .busy_o         (busy),
    .seq_o          (seq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Byte capture; a write takes effect at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && wr) q.push_back(wdata);
    if (full) chk("wr_while_full", 32'(wr), 32'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [15:0] a, input logic [15:0] b, input logic [7:0] exp_seq,
                       input int full_start, input int full_len, input int valid_gap,
                       input bit drop_en);
    logic [7:0] exp[$];
    logic [15:0] s[2];
    logic [7:0] cs, held;
    int idx, gap;
    bit started, ended, acc;
    s[0] = a;
    s[1] = b;
    exp = '{DEF_SYNC0, DEF_SYNC1, exp_seq, 8'h02, a[15:8], a[7:0], b[15:8], b[7:0]};
    cs = 8'h00;
    for (int i = 2; i < 8; i++) cs = cs ^ exp[i];
    if (CHK) exp.push_back(cs);
    q.delete();
    idx = 0; gap = 0; started = 0; ended = 0; held = 8'h00;
    for (int c = 0; c < 200; c++) begin
      full  = (c >= full_start) && (c < full_start + full_len);
      en    = drop_en ? (idx == 0) : 1'b1;
      valid = (idx < 2);
      sdata = (idx < 2) ? s[idx] : 16'h0;
      if (ready && idx == 0 && gap < valid_gap) begin
        valid = 1'b0;
        gap++;
        chk("stall_wr", 32'(wr), 32'd0);
        chk("stall_rdy", 32'(ready), 32'd1);
      end
      if (full && c > full_start) chk("bp_hold", 32'(wdata), 32'(held));
      held = wdata;
      if (busy) started = 1;
      if (started && !busy) begin
        ended = 1;
        break;
      end
      acc = ready && valid;
      step();
      if (acc) idx++;
    end
    en = 1'b0; valid = 1'b0; full = 1'b0;
    chk("frame_done", 32'(ended), 32'd1);
    chk("frame_len", 32'(q.size()), 32'(FLEN));
    for (int i = 0; i < exp.size() && i < q.size(); i++)
      chk($sformatf("byte%0d", i), 32'(q[i]), 32'(exp[i]));
    chk("seq_after", 32'(seq), 32'(exp_seq + 8'd1));
  endtask

  initial begin
    int idle_cnt;
    bit started, done;

    // Reset state
    step(); step();
    chk("rst_wr", 32'(wr), 32'd0);
    chk("rst_data", 32'(wdata), 32'd0);
    chk("rst_rdy", 32'(ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_seq", 32'(seq), 32'd0);
    rst_n = 1'b1;
    step();

    // Basic frame: A5 5A 00 02 12 34 AB CD [42]
    frame(16'h1234, 16'hABCD, 8'h00, 1000, 0, 0, 1'b0);
    // Backpressure during first SHIFT byte for 3 cycles
    frame(16'h1234, 16'hABCD, 8'h01, 6, 3, 0, 1'b0);
    // Sample stall: valid low for 5 LOAD cycles
    frame(16'hBEEF, 16'h0001, 8'h02, 1000, 0, 5, 1'b0);

    // Reset mid-SHIFT
    en = 1'b1; valid = 1'b1; sdata = 16'h5555;
    for (int i = 0; i < 20 && !ready; i++) step();
    chk("pre_rst_ready", 32'(ready), 32'd1);
    step();
    chk("pre_rst_shift_wr", 32'(wr), 32'd1);
    rst_n = 1'b0; en = 1'b0; valid = 1'b0;
    step();
    chk("midrst_wr", 32'(wr), 32'd0);
    chk("midrst_data", 32'(wdata), 32'd0);
    chk("midrst_rdy", 32'(ready), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_seq", 32'(seq), 32'd0);
    rst_n = 1'b1;
    step();
    frame(16'h1111, 16'h2222, 8'h00, 1000, 0, 0, 1'b0);

    // 257 back-to-back frames from seq 0
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    q.delete();
    en = 1'b1; valid = 1'b1; sdata = 16'h0000;
    idle_cnt = 0; started = 0; done = 0;
    for (int c = 0; c < 257 * 13 + 100; c++) begin
      if (q.size() == 257 * FLEN) begin
        done = 1;
        break;
      end
      if (started && !busy) idle_cnt++;
      if (busy) started = 1;
      step();
    end
    en = 1'b0; valid = 1'b0;
    chk("wrap_done", 32'(done), 32'd1);
    chk("wrap_idle_gaps", 32'(idle_cnt), 32'd256);
    for (int f = 0; f < 257 && (f + 1) * FLEN <= q.size(); f++) begin
      chk($sformatf("wrap_sync0_f%0d", f), 32'(q[f*FLEN]), 32'(DEF_SYNC0));
      chk($sformatf("wrap_seq_f%0d", f), 32'(q[f*FLEN+2]), 32'(f % 256));
    end
    chk("wrap_seq_o", 32'(seq), 32'd1);
    step();

    // en dropped during first data byte: frame completes, then stays idle
    frame(16'hC3C3, 16'h7E81, 8'h01, 1000, 0, 0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_drop_busy", 32'(busy), 32'd0);
      chk("post_drop_wr", 32'(wr), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
